// File: rtl/missile_fire_ctrl.sv
// Purpose  : shoot-key to one-clock fire pulse, with missile lifetime tracking, frame cooldown and ammo.
// Latency  : keyFire rise to firePulse is 3 clocks (2-flop sync plus the registered pulse).
// Backpress: none; key edges seen outside READY are dropped, never queued.
//
// Ports:
//   clk, resetN          clock, asynchronous active-low reset
//   startOfFrame         one-clock pulse per video frame
//   keyFire              raw shoot key level (asynchronous to clk)
//   missileActive        mover drawEn, high while the missile is in flight
//   missileHit           mover collision pulse
//   firePulse            one-clock fire request to the mover
//   ammoCount            rounds remaining
//   ready                READY state with ammo left
//   state                FSM state for debug (READY=0 FIRED=1 INFLIGHT=2 COOLDOWN=3)
// Build option: define AUTO_RELOAD_EN to refill one round every RELOAD_FRAMES frames.
module missile_fire_ctrl #(
    parameter int MAX_AMMO        = 5,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int ACK_TIMEOUT     = 4,
    parameter int RELOAD_FRAMES   = 60
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       keyFire,
    input  logic       missileActive,
    input  logic       missileHit,
    output logic       firePulse,
    output logic [3:0] ammoCount,
    output logic       ready,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_FIRED    = 2'd1,
        ST_INFLIGHT = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_t;

    localparam logic [3:0] AMMO_MAX   = 4'(MAX_AMMO);
    localparam logic [3:0] ACK_LAST   = 4'(ACK_TIMEOUT - 1);
    localparam logic [7:0] FRAME_LAST = 8'(COOLDOWN_FRAMES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_key_s1;
    logic       r_key_s2;
    logic       r_key_d;
    logic       w_key_edge;
    logic       r_fire;
    logic       w_fire;
    logic       w_refill;
    logic [3:0] r_ack_cnt;
    logic [7:0] r_frame_cnt;
    logic [3:0] r_ammo;

    // Two-flop synchroniser followed by a rising-edge detector; a held key gives one edge.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_key_s1 <= 1'b0;
            r_key_s2 <= 1'b0;
            r_key_d  <= 1'b0;
        end else begin
            r_key_s1 <= keyFire;
            r_key_s2 <= r_key_s1;
            r_key_d  <= r_key_s2;
        end
    end

    assign w_key_edge = r_key_s2 & ~r_key_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= ST_READY;
            r_fire  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fire  <= w_fire;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fire      = 1'b0;
        case (r_state)
            ST_READY: begin
                if (w_key_edge && (r_ammo != 4'd0)) begin
                    w_fire      = 1'b1;
                    w_state_nxt = ST_FIRED;
                end
            end
            ST_FIRED: begin
                // A hit before the ack is both the ack and the end of the flight.
                if (missileHit)
                    w_state_nxt = ST_COOLDOWN;
                else if (missileActive)
                    w_state_nxt = ST_INFLIGHT;
                else if (r_ack_cnt == ACK_LAST)
                    w_state_nxt = ST_COOLDOWN;
            end
            ST_INFLIGHT: begin
                if (!missileActive || missileHit)
                    w_state_nxt = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (startOfFrame && (r_frame_cnt == FRAME_LAST))
                    w_state_nxt = ST_READY;
            end
            default: w_state_nxt = ST_READY;
        endcase
    end

    // Counters are held at zero outside their state, so they start clean on entry;
    // a frame pulse on the COOLDOWN entry clock therefore is not counted.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_ack_cnt   <= 4'd0;
            r_frame_cnt <= 8'd0;
        end else begin
            if (r_state != ST_FIRED)
                r_ack_cnt <= 4'd0;
            else
                r_ack_cnt <= r_ack_cnt + 4'd1;

            if (r_state != ST_COOLDOWN)
                r_frame_cnt <= 8'd0;
            else if (startOfFrame)
                r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

`ifdef AUTO_RELOAD_EN
    localparam logic [7:0] RELOAD_LAST = 8'(RELOAD_FRAMES - 1);
    logic [7:0] r_reload_cnt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_reload_cnt <= 8'd0;
        else if (r_ammo == AMMO_MAX)
            r_reload_cnt <= 8'd0;
        else if (startOfFrame) begin
            if (r_reload_cnt == RELOAD_LAST)
                r_reload_cnt <= 8'd0;
            else
                r_reload_cnt <= r_reload_cnt + 8'd1;
        end
    end

    assign w_refill = startOfFrame && (r_reload_cnt == RELOAD_LAST) && (r_ammo < AMMO_MAX);
`else
    logic [7:0] w_unused_reload;
    assign w_unused_reload = 8'(RELOAD_FRAMES);
    assign w_refill        = 1'b0;
`endif

    // Fire only happens with ammo > 0 and refill only below the ceiling, so both saturate;
    // a fire and a refill on the same clock cancel out.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            r_ammo <= AMMO_MAX;
        else begin
            case ({w_fire, w_refill})
                2'b10:   r_ammo <= r_ammo - 4'd1;
                2'b01:   r_ammo <= r_ammo + 4'd1;
                default: r_ammo <= r_ammo;
            endcase
        end
    end

    assign firePulse = r_fire;
    assign ammoCount = r_ammo;
    assign state     = r_state;
    assign ready     = (r_state == ST_READY) && (r_ammo != 4'd0);

endmodule

// File: tb/tb_missile_fire_ctrl.sv
module tb_missile_fire_ctrl;

    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       keyFire = 1'b0;
    logic       missileActive = 1'b0;
    logic       missileHit = 1'b0;
    logic       firePulse;
    logic [3:0] ammoCount;
    logic       ready;
    logic [1:0] state;

    int n_total = 0;
    int n_bad   = 0;

    missile_fire_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .keyFire(keyFire),
        .missileActive(missileActive), .missileHit(missileHit),
        .firePulse(firePulse), .ammoCount(ammoCount), .ready(ready), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    // Press the key, expect the pulse exactly 3 clocks later, then release the key.
    task automatic press_and_fire(input logic [3:0] exp_ammo);
        keyFire = 1'b1;
        tick(); tick(); tick();
        n_total++; if (firePulse !== 1'b1) begin n_bad++; $display("FAIL fire_pulse: got %0d want 1", firePulse); end
        n_total++; if (state !== 2'd1) begin n_bad++; $display("FAIL fire_state: got %0d want 1", state); end
        n_total++; if (ammoCount !== exp_ammo) begin n_bad++; $display("FAIL fire_ammo: got %0d want %0d", ammoCount, exp_ammo); end
        keyFire = 1'b0;
    endtask

    task automatic test_reset;
        #2 resetN = 1'b0;
        #1;
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state); end
        n_total++; if (ammoCount !== 4'd5) begin n_bad++; $display("FAIL rst_ammo: got %0d want 5", ammoCount); end
        n_total++; if (firePulse !== 1'b0) begin n_bad++; $display("FAIL rst_pulse: got %0d want 0", firePulse); end
        n_total++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %0d want 1", ready); end
        tick(); tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_hold_key;
        int pulses;
        pulses = 0;
        keyFire = 1'b1;
        tick();
        n_total++; if (firePulse !== 1'b0) begin n_bad++; $display("FAIL lat_clk1: got %0d want 0", firePulse); end
        tick();
        n_total++; if (firePulse !== 1'b0) begin n_bad++; $display("FAIL lat_clk2: got %0d want 0", firePulse); end
        tick();
        n_total++; if (firePulse !== 1'b1) begin n_bad++; $display("FAIL lat_clk3: got %0d want 1", firePulse); end
        n_total++; if (state !== 2'd1) begin n_bad++; $display("FAIL hold_state: got %0d want 1", state); end
        n_total++; if (ammoCount !== 4'd4) begin n_bad++; $display("FAIL hold_ammo: got %0d want 4", ammoCount); end
        for (int i = 0; i < 97; i++) begin
            tick();
            if (firePulse) pulses++;
        end
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL hold_extra_pulses: got %0d want 0", pulses); end
        n_total++; if (state !== 2'd3) begin n_bad++; $display("FAIL hold_cooldown: got %0d want 3", state); end
        keyFire = 1'b0;
        frames(7);
        n_total++; if (state !== 2'd3) begin n_bad++; $display("FAIL hold_cd7: got %0d want 3", state); end
        frames(1);
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL hold_cd8: got %0d want 0", state); end
    endtask

    task automatic test_inflight;
        int pulses;
        press_and_fire(4'd3);
        missileActive = 1'b1;
        tick();
        n_total++; if (state !== 2'd2) begin n_bad++; $display("FAIL inflight_enter: got %0d want 2", state); end
        n_total++; if (firePulse !== 1'b0) begin n_bad++; $display("FAIL inflight_pulse_len: got %0d want 0", firePulse); end
        pulses = 0;
        keyFire = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); if (firePulse) pulses++; end
        keyFire = 1'b0;
        for (int i = 0; i < 44; i++) begin tick(); if (firePulse) pulses++; end
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL inflight_key_drop: got %0d want 0", pulses); end
        n_total++; if (state !== 2'd2) begin n_bad++; $display("FAIL inflight_hold: got %0d want 2", state); end
        missileActive = 1'b0;
        tick();
        n_total++; if (state !== 2'd3) begin n_bad++; $display("FAIL inflight_end: got %0d want 3", state); end
        pulses = 0;
        keyFire = 1'b1;
        for (int i = 0; i < 5; i++) begin tick(); if (firePulse) pulses++; end
        keyFire = 1'b0;
        tick();
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL cooldown_key_drop: got %0d want 0", pulses); end
        frames(7);
        n_total++; if (state !== 2'd3) begin n_bad++; $display("FAIL inflight_cd7: got %0d want 3", state); end
        frames(1);
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL inflight_cd8: got %0d want 0", state); end
        n_total++; if (ready !== 1'b1) begin n_bad++; $display("FAIL inflight_ready: got %0d want 1", ready); end
    endtask

    task automatic test_ack_timeout;
        press_and_fire(4'd2);
        tick(); tick(); tick();
        n_total++; if (state !== 2'd1) begin n_bad++; $display("FAIL ack_wait3: got %0d want 1", state); end
        startOfFrame = 1'b1;  // coincides with the COOLDOWN entry clock
        tick();
        startOfFrame = 1'b0;
        n_total++; if (state !== 2'd3) begin n_bad++; $display("FAIL ack_timeout4: got %0d want 3", state); end
        n_total++; if (ammoCount !== 4'd2) begin n_bad++; $display("FAIL ack_no_refund: got %0d want 2", ammoCount); end
        tick();
        frames(7);
        n_total++; if (state !== 2'd3) begin n_bad++; $display("FAIL sof_entry_not_counted: got %0d want 3", state); end
        frames(1);
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL ack_cd8: got %0d want 0", state); end
    endtask

    task automatic test_hit_in_fired;
        press_and_fire(4'd1);
        missileHit = 1'b1;
        tick();
        missileHit = 1'b0;
        n_total++; if (state !== 2'd3) begin n_bad++; $display("FAIL hit_fired: got %0d want 3", state); end
        frames(8);
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL hit_cd8: got %0d want 0", state); end
    endtask

    task automatic test_ammo_empty;
        int pulses;
        press_and_fire(4'd0);
        missileActive = 1'b1;
        tick();
        n_total++; if (state !== 2'd2) begin n_bad++; $display("FAIL empty_inflight: got %0d want 2", state); end
        missileHit = 1'b1;
        tick();
        missileHit = 1'b0;
        missileActive = 1'b0;
        n_total++; if (state !== 2'd3) begin n_bad++; $display("FAIL empty_hit_end: got %0d want 3", state); end
        frames(8);
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL empty_state: got %0d want 0", state); end
        n_total++; if (ready !== 1'b0) begin n_bad++; $display("FAIL empty_ready: got %0d want 0", ready); end
        pulses = 0;
        keyFire = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(); if (firePulse) pulses++; end
        keyFire = 1'b0;
        tick();
        n_total++; if (pulses !== 0) begin n_bad++; $display("FAIL empty_no_pulse: got %0d want 0", pulses); end
        n_total++; if (ammoCount !== 4'd0) begin n_bad++; $display("FAIL empty_ammo: got %0d want 0", ammoCount); end
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL empty_stay_ready: got %0d want 0", state); end
    endtask

    task automatic test_reset_inflight;
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        n_total++; if (ammoCount !== 4'd5) begin n_bad++; $display("FAIL rearm_ammo: got %0d want 5", ammoCount); end
        // Reset while the pulse is high clears it without a clock edge.
        press_and_fire(4'd4);
        resetN = 1'b0;
        #1;
        n_total++; if (firePulse !== 1'b0) begin n_bad++; $display("FAIL rst_pulse_async: got %0d want 0", firePulse); end
        tick();
        resetN = 1'b1;
        tick();
        press_and_fire(4'd4);
        missileActive = 1'b1;
        tick();
        n_total++; if (state !== 2'd2) begin n_bad++; $display("FAIL rst_pre_inflight: got %0d want 2", state); end
        #2 resetN = 1'b0;
        #1;
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_mid_state: got %0d want 0", state); end
        n_total++; if (ammoCount !== 4'd5) begin n_bad++; $display("FAIL rst_mid_ammo: got %0d want 5", ammoCount); end
        n_total++; if (firePulse !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pulse: got %0d want 0", firePulse); end
        tick();
        resetN = 1'b1;
        missileActive = 1'b0;
        tick();
        n_total++; if (state !== 2'd0) begin n_bad++; $display("FAIL rst_after: got %0d want 0", state); end
    endtask

`ifdef AUTO_RELOAD_EN
    task automatic test_reload;
        // Two timeout cycles: 16 frames counted toward reload while ammo is below the ceiling.
        press_and_fire(4'd4);
        tick(); tick(); tick(); tick();
        frames(8);
        press_and_fire(4'd3);
        tick(); tick(); tick(); tick();
        frames(8);
        frames(43);
        n_total++; if (ammoCount !== 4'd3) begin n_bad++; $display("FAIL reload_before: got %0d want 3", ammoCount); end
        frames(1);
        n_total++; if (ammoCount !== 4'd4) begin n_bad++; $display("FAIL reload_refill: got %0d want 4", ammoCount); end
        press_and_fire(4'd3);
        tick(); tick(); tick(); tick();
        frames(8);
        frames(51);
        n_total++; if (ammoCount !== 4'd3) begin n_bad++; $display("FAIL reload_before2: got %0d want 3", ammoCount); end
        keyFire = 1'b1;
        tick(); tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        keyFire = 1'b0;
        n_total++; if (firePulse !== 1'b1) begin n_bad++; $display("FAIL reload_fire_pulse: got %0d want 1", firePulse); end
        n_total++; if (ammoCount !== 4'd3) begin n_bad++; $display("FAIL reload_fire_net0: got %0d want 3", ammoCount); end
    endtask
`endif

    initial begin
        test_reset();
        test_hold_key();
        test_inflight();
        test_ack_timeout();
        test_hit_in_fired();
        test_ammo_empty();
        test_reset_inflight();
`ifdef AUTO_RELOAD_EN
        test_reload();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
